// File: rtl/quotient_bcd_formatter.sv
// -----------------------------------------------------------------------------
// quotient_bcd_formatter
//
// Takes one unsigned fixed-point quotient (ARG_BIT_WIDTH integer bits above
// PRECISION fraction bits) from the sequential divider. It converts the integer
// part to BCD with one double-dabble step per cycle. It then streams decimal
// digits, one per valid/ready beat: integer digits MSD first with leading zeros
// suppressed, followed by FRAC_DIGITS truncated fraction digits. A
// divide-by-zero transaction emits a single 4'hF beat flagged with dz_out.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   in_valid       quotient/dz_in valid
//   in_ready       high only while idle
//   quotient       {integer part, fraction part}
//   dz_in          divide-by-zero flag from the divider
//   out_valid      digit beat valid
//   out_ready      consumer accepts the beat
//   digit          BCD digit (4'hF on a divide-by-zero beat)
//   digit_is_frac  beat is a fraction digit
//   digit_last     final beat of the transaction
//   dz_out         divide-by-zero beat
// -----------------------------------------------------------------------------
module quotient_bcd_formatter #(
    parameter int ARG_BIT_WIDTH = 32,
    parameter int PRECISION     = 64,
    parameter int INT_DIGITS    = 10,
    parameter int FRAC_DIGITS   = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ARG_BIT_WIDTH+PRECISION-1:0] quotient,
    input  logic                               dz_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [3:0]                         digit,
    output logic                               digit_is_frac,
    output logic                               digit_last,
    output logic                               dz_out
);

    localparam int QW    = ARG_BIT_WIDTH + PRECISION;
    localparam int BW    = INT_DIGITS * 4;
    localparam int CNT_W = $clog2(ARG_BIT_WIDTH + 1);
    localparam int PTR_W = (INT_DIGITS > 1) ? $clog2(INT_DIGITS) : 1;
    localparam int FC_W  = $clog2(FRAC_DIGITS + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONVERT   = 3'd1,
        EMIT_INT  = 3'd2,
        EMIT_FRAC = 3'd3,
        EMIT_DZ   = 3'd4
    } state_t;

    state_t                   state_r, state_s;
    logic [ARG_BIT_WIDTH-1:0] int_r, int_s;
    logic [PRECISION-1:0]     frac_r, frac_s;
    logic [BW-1:0]            bcd_r, bcd_s;
    logic [CNT_W-1:0]         step_r, step_s;
    logic [PTR_W-1:0]         ptr_r, ptr_s;
    logic [FC_W-1:0]          fcnt_r, fcnt_s;

    logic [BW-1:0]            bcd_shift_s;
    logic [PTR_W-1:0]         lead_ptr_s;
    logic [PRECISION+3:0]     p_cur_s;
    logic [PRECISION+3:0]     p_nxt_s;
    logic                     accept_s;
    logic                     fire_s;

    logic                     out_valid_s;
    logic [3:0]               digit_s;
    logic                     digit_is_frac_s;
    logic                     digit_last_s;
    logic                     dz_out_s;
    logic                     in_ready_s;

    // frac * 10 as (frac << 3) + (frac << 1); the top nibble is the next digit
    function automatic logic [PRECISION+3:0] mul10(input logic [PRECISION-1:0] f);
        logic [PRECISION+3:0] w;
        w = {4'd0, f};
        return (w << 3) + (w << 1);
    endfunction

    assign accept_s = in_valid && in_ready;
    assign fire_s   = out_valid && out_ready;
    assign p_cur_s  = mul10(frac_r);

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the integer MSB
    always_comb begin
        logic [BW-1:0] adj;
        adj = bcd_r;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (bcd_r[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd_r[i*4 +: 4] + 4'd3;
            end else begin
                adj[i*4 +: 4] = bcd_r[i*4 +: 4];
            end
        end
        bcd_shift_s = {adj[BW-2:0], int_r[ARG_BIT_WIDTH-1]};
    end

    // Most-significant nonzero nibble of the finished BCD value (0 when the integer is 0)
    always_comb begin
        lead_ptr_s = '0;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (bcd_shift_s[i*4 +: 4] != 4'd0) begin
                lead_ptr_s = PTR_W'(i);
            end else begin
                lead_ptr_s = lead_ptr_s;
            end
        end
    end

    // Next-state logic for the FSM and its datapath registers
    always_comb begin
        state_s = state_r;
        int_s   = int_r;
        frac_s  = frac_r;
        bcd_s   = bcd_r;
        step_s  = step_r;
        ptr_s   = ptr_r;
        fcnt_s  = fcnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s && dz_in) begin
                    state_s = EMIT_DZ;
                end else if (accept_s) begin
                    state_s = CONVERT;
                    int_s   = quotient[QW-1:PRECISION];
                    frac_s  = quotient[PRECISION-1:0];
                    bcd_s   = '0;
                    step_s  = CNT_W'(ARG_BIT_WIDTH);
                    ptr_s   = '0;
                    fcnt_s  = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            CONVERT: begin
                bcd_s  = bcd_shift_s;
                int_s  = int_r << 1;
                step_s = step_r - CNT_W'(1);
                if (step_r == CNT_W'(1)) begin
                    state_s = EMIT_INT;
                    ptr_s   = lead_ptr_s;
                end else begin
                    state_s = CONVERT;
                end
            end
            EMIT_INT: begin
                if (fire_s && (ptr_r == '0)) begin
                    state_s = EMIT_FRAC;
                    fcnt_s  = '0;
                end else if (fire_s) begin
                    ptr_s = ptr_r - PTR_W'(1);
                end else begin
                    state_s = EMIT_INT;
                end
            end
            EMIT_FRAC: begin
                if (fire_s) begin
                    frac_s = p_cur_s[PRECISION-1:0];
                    if (fcnt_r == FC_W'(FRAC_DIGITS - 1)) begin
                        state_s = IDLE;
                        fcnt_s  = '0;
                    end else begin
                        fcnt_s = fcnt_r + FC_W'(1);
                    end
                end else begin
                    state_s = EMIT_FRAC;
                end
            end
            EMIT_DZ: begin
                if (fire_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = EMIT_DZ;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output values for the next cycle, decoded from the next-state registers so
    // the outputs themselves can be registered without adding latency
    always_comb begin
        p_nxt_s         = mul10(frac_s);
        out_valid_s     = 1'b0;
        digit_s         = 4'd0;
        digit_is_frac_s = 1'b0;
        digit_last_s    = 1'b0;
        dz_out_s        = 1'b0;
        in_ready_s      = 1'b0;
        case (state_s)
            IDLE: begin
                in_ready_s = 1'b1;
            end
            CONVERT: begin
                out_valid_s = 1'b0;
            end
            EMIT_INT: begin
                out_valid_s = 1'b1;
                digit_s     = bcd_s[{ptr_s, 2'b00} +: 4];
            end
            EMIT_FRAC: begin
                out_valid_s     = 1'b1;
                digit_s         = p_nxt_s[PRECISION+3:PRECISION];
                digit_is_frac_s = 1'b1;
                digit_last_s    = (fcnt_s == FC_W'(FRAC_DIGITS - 1));
            end
            EMIT_DZ: begin
                out_valid_s  = 1'b1;
                digit_s      = 4'hF;
                digit_last_s = 1'b1;
                dz_out_s     = 1'b1;
            end
            default: begin
                in_ready_s = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            int_r         <= '0;
            frac_r        <= '0;
            bcd_r         <= '0;
            step_r        <= '0;
            ptr_r         <= '0;
            fcnt_r        <= '0;
            out_valid     <= 1'b0;
            digit         <= 4'd0;
            digit_is_frac <= 1'b0;
            digit_last    <= 1'b0;
            dz_out        <= 1'b0;
            in_ready      <= 1'b1;
        end else begin
            state_r       <= state_s;
            int_r         <= int_s;
            frac_r        <= frac_s;
            bcd_r         <= bcd_s;
            step_r        <= step_s;
            ptr_r         <= ptr_s;
            fcnt_r        <= fcnt_s;
            out_valid     <= out_valid_s;
            digit         <= digit_s;
            digit_is_frac <= digit_is_frac_s;
            digit_last    <= digit_last_s;
            dz_out        <= dz_out_s;
            in_ready      <= in_ready_s;
        end
    end

endmodule

// File: tb/tb_quotient_bcd_formatter.sv
// -----------------------------------------------------------------------------
// tb_quotient_bcd_formatter
//
// Directed bench for quotient_bcd_formatter: hand-computed digit strings for
// several quotients, divide-by-zero, backpressure and mid-conversion reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_quotient_bcd_formatter;

    localparam int ARG_BIT_WIDTH = 32;
    localparam int PRECISION     = 64;
    localparam int FIRST_LAT     = ARG_BIT_WIDTH + 1;

    logic                               clk;
    logic                               rst;
    logic                               in_valid;
    logic                               in_ready;
    logic [ARG_BIT_WIDTH+PRECISION-1:0] quotient;
    logic                               dz_in;
    logic                               out_valid;
    logic                               out_ready;
    logic [3:0]                         digit;
    logic                               digit_is_frac;
    logic                               digit_last;
    logic                               dz_out;

    int vectors;
    int miscompares;

    quotient_bcd_formatter #(
        .ARG_BIT_WIDTH (ARG_BIT_WIDTH),
        .PRECISION     (PRECISION),
        .INT_DIGITS    (10),
        .FRAC_DIGITS   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .quotient      (quotient),
        .dz_in         (dz_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .digit         (digit),
        .digit_is_frac (digit_is_frac),
        .digit_last    (digit_last),
        .dz_out        (dz_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one non-dz quotient and check every beat against the digit string.
    // stall_at >= 0 holds out_ready low for 5 cycles on that beat and pulses
    // in_valid meanwhile.
    task automatic run_txn(input string tag, input logic [95:0] q,
                           input string exp, input int n_int, input int stall_at);
        int lat;
        int n;
        logic [3:0] held;
        n = exp.len();
        chk({tag, " in_ready before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        quotient = q;
        dz_in    = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " first latency"}, 32'(lat), 32'(FIRST_LAT));
        for (int b = 0; b < n; b++) begin
            if (b == stall_at) begin
                out_ready = 1'b0;
                held      = digit;
                in_valid  = 1'b1;
                dz_in     = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    dz_in    = 1'b0;
                    chk({tag, " stall valid"}, 32'(out_valid), 32'd1);
                    chk({tag, " stall digit"}, 32'(digit), 32'(held));
                    chk({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
                    chk({tag, " stall last"}, 32'(digit_last), 32'd0);
                end
                out_ready = 1'b1;
            end
            chk({tag, " valid"}, 32'(out_valid), 32'd1);
            chk({tag, " digit"}, 32'(digit), 32'(int'(exp.getc(b)) - 48));
            chk({tag, " is_frac"}, 32'(digit_is_frac), 32'(b >= n_int));
            chk({tag, " last"}, 32'(digit_last), 32'(b == n - 1));
            chk({tag, " dz_out"}, 32'(dz_out), 32'd0);
            chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        chk({tag, " valid after"}, 32'(out_valid), 32'd0);
        chk({tag, " in_ready after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen_valid;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        quotient  = '0;
        dz_in     = 1'b0;
        repeat (2) @(negedge clk);

        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset digit", 32'(digit), 32'd0);
        chk("reset is_frac", 32'(digit_is_frac), 32'd0);
        chk("reset last", 32'(digit_last), 32'd0);
        chk("reset dz_out", 32'(dz_out), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run_txn("3.5", {32'd3, 64'h8000_0000_0000_0000}, "350000000", 1, -1);
        run_txn("1/3", {32'd0, 64'h5555_5555_5555_5555}, "033333333", 1, -1);
        run_txn("max", {32'hFFFF_FFFF, 64'd0}, "429496729500000000", 10, -1);
        run_txn("1000", {32'd1000, 64'd0}, "100000000000", 4, -1);

        // divide-by-zero: single beat, one cycle after accept
        chk("dz in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dz_in    = 1'b1;
        quotient = {32'd1234, 64'hDEAD_BEEF_0000_0001};
        @(negedge clk);
        in_valid = 1'b0;
        dz_in    = 1'b0;
        chk("dz valid", 32'(out_valid), 32'd1);
        chk("dz digit", 32'(digit), 32'hF);
        chk("dz dz_out", 32'(dz_out), 32'd1);
        chk("dz last", 32'(digit_last), 32'd1);
        chk("dz is_frac", 32'(digit_is_frac), 32'd0);
        @(negedge clk);
        chk("dz valid after", 32'(out_valid), 32'd0);
        chk("dz in_ready after", 32'(in_ready), 32'd1);

        // backpressure on the 2nd fraction beat (beat index 2)
        run_txn("3.5 stall", {32'd3, 64'h8000_0000_0000_0000}, "350000000", 1, 2);

        // reset in the middle of the conversion
        in_valid = 1'b1;
        quotient = {32'd3, 64'h8000_0000_0000_0000};
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrst busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        chk("midrst no beats", 32'(seen_valid), 32'd0);
        run_txn("3.5 after rst", {32'd3, 64'h8000_0000_0000_0000}, "350000000", 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
